// File: rtl/dmem_wait_ctrl.sv
// Big-endian byte-addressed data memory with valid/ready requests and a fixed LATENCY-cycle response.
// One request in flight at a time; req_ready drops until the response pulse has gone out.
module dmem_wait_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("dmem_wait_ctrl: DATA_W must be 32");
  end
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dmem_wait_ctrl: LATENCY must be 1..15");
  end
  if (DEPTH_BYTES < 4 || (DEPTH_BYTES & (DEPTH_BYTES - 1)) != 0) begin : g_bad_depth
    $error("dmem_wait_ctrl: DEPTH_BYTES must be a power of two >= 4");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [7:0]        mem_q [DEPTH_BYTES];

  logic              accept;
  logic [2:0]        nbytes;
  logic [ADDR_W:0]   end_addr;
  logic              align_err, range_err, req_err;
  logic [IDX_W-1:0]  idx0, idx1, idx2, idx3;
  logic [7:0]        b0, b1, b2, b3;
  logic [DATA_W-1:0] load_val;

  assign req_ready = (state_q == S_IDLE) & ~reset;
  assign accept    = req_valid & req_ready;

  always_comb begin
    nbytes = 3'd4;
    case (req_size)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  end

  // One extra bit so an access near the top of the address space cannot wrap back into range.
  assign end_addr  = {1'b0, req_addr} + (ADDR_W+1)'(nbytes);
  assign range_err = end_addr > (ADDR_W+1)'(DEPTH_BYTES);
  assign align_err = (req_size == 2'b11)
                   | ((req_size == 2'b01) & req_addr[0])
                   | ((req_size == 2'b10) & (|req_addr[1:0]));
  assign req_err   = align_err | range_err;

  assign idx0 = req_addr[IDX_W-1:0];
  assign idx1 = idx0 + IDX_W'(1);
  assign idx2 = idx0 + IDX_W'(2);
  assign idx3 = idx0 + IDX_W'(3);
  assign b0   = mem_q[idx0];
  assign b1   = mem_q[idx1];
  assign b2   = mem_q[idx2];
  assign b3   = mem_q[idx3];

  always_comb begin
    load_val = {b0, b1, b2, b3};
    case (req_size)
      2'b00:   load_val = {{24{req_signed & b0[7]}}, b0};
      2'b01:   load_val = {{16{req_signed & b0[7]}}, b0, b1};
      default: load_val = {b0, b1, b2, b3};
    endcase
  end

  // Stores commit on the accept edge; the array has no reset.
  always_ff @(posedge clk) begin
    if (accept && req_write && !req_err) begin
      case (req_size)
        2'b00: mem_q[idx0] <= req_wdata[7:0];
        2'b01: begin
          mem_q[idx0] <= req_wdata[15:8];
          mem_q[idx1] <= req_wdata[7:0];
        end
        default: begin
          mem_q[idx0] <= req_wdata[31:24];
          mem_q[idx1] <= req_wdata[23:16];
          mem_q[idx2] <= req_wdata[15:8];
          mem_q[idx3] <= req_wdata[7:0];
        end
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d   = CNT_INIT;
          err_d   = req_err;
          rdata_d = (req_write | req_err) ? '0 : load_val;
          state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_err   = rsp_valid & err_q;

endmodule
